// File: rtl/decode_pkg.sv
// Shared decode types for the ID/EX slice: control bundle, instruction field
// positions and the RV32 control / immediate decoders.
package decode_pkg;

  typedef struct packed {
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [2:0] MemWrite;
    logic [2:0] MemRead;
    logic       Jump;
    logic       Branch;
    logic [4:0] AluControl;
    logic       mux2;
    logic       mux3;
    logic       mux4;
  } ctrl_t;

  localparam ctrl_t      CTRL_NOP = '0;
  localparam logic [2:0] MEM_NONE = 3'd0;

  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int RD_LSB  = 7;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Access codes are 1-based so that 0 always means "no memory access".
  function automatic logic [2:0] load_code(input logic [2:0] f3);
    case (f3)
      3'b000:  load_code = 3'd1;
      3'b001:  load_code = 3'd2;
      3'b010:  load_code = 3'd3;
      3'b100:  load_code = 3'd4;
      3'b101:  load_code = 3'd5;
      default: load_code = MEM_NONE;
    endcase
  endfunction

  function automatic logic [2:0] store_code(input logic [2:0] f3);
    case (f3)
      3'b000:  store_code = 3'd1;
      3'b001:  store_code = 3'd2;
      3'b010:  store_code = 3'd3;
      default: store_code = MEM_NONE;
    endcase
  endfunction

  function automatic ctrl_t decode_ctrl(input logic [31:0] instr);
    ctrl_t      c;
    logic [2:0] f3;
    logic       f7b5;
    c    = CTRL_NOP;
    f3   = instr[14:12];
    f7b5 = instr[30];
    case (instr[6:0])
      OP_R: begin
        c.RegWrite   = 1'b1;
        c.AluControl = {1'b0, f7b5, f3};
      end
      OP_I: begin
        c.RegWrite   = 1'b1;
        c.mux2       = 1'b1;
        c.AluControl = {1'b0, (f3 == 3'b101) & f7b5, f3};
      end
      OP_LOAD: begin
        c.RegWrite  = 1'b1;
        c.mux2      = 1'b1;
        c.ResultSrc = 2'b01;
        c.MemRead   = load_code(f3);
      end
      OP_STORE: begin
        c.mux2     = 1'b1;
        c.MemWrite = store_code(f3);
      end
      OP_BRANCH: begin
        c.Branch     = 1'b1;
        c.AluControl = {2'b10, f3};
      end
      OP_JAL: begin
        c.RegWrite  = 1'b1;
        c.Jump      = 1'b1;
        c.ResultSrc = 2'b10;
        c.mux3      = 1'b1;
      end
      OP_JALR: begin
        c.RegWrite  = 1'b1;
        c.Jump      = 1'b1;
        c.ResultSrc = 2'b10;
        c.mux2      = 1'b1;
        c.mux4      = 1'b1;
      end
      OP_LUI: begin
        c.RegWrite  = 1'b1;
        c.ResultSrc = 2'b11;
      end
      OP_AUIPC: begin
        c.RegWrite = 1'b1;
        c.mux2     = 1'b1;
        c.mux3     = 1'b1;
      end
      default: c = CTRL_NOP;
    endcase
    return c;
  endfunction

  function automatic logic [31:0] ext_imm(input logic [31:0] i);
    case (i[6:0])
      OP_I, OP_LOAD, OP_JALR: ext_imm = {{20{i[31]}}, i[31:20]};
      OP_STORE:               ext_imm = {{20{i[31]}}, i[31:25], i[11:7]};
      OP_BRANCH:              ext_imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      OP_JAL:                 ext_imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      OP_LUI, OP_AUIPC:       ext_imm = {i[31:12], 12'h000};
      default:                ext_imm = 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/rv_regfile.sv
// Two-read / one-write register file; x0 and out-of-range indices read as 0,
// optional write-through so a W-stage write is visible in the same cycle.
module rv_regfile #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      ra1_i,
  input  logic [4:0]      ra2_i,
  input  logic            we_i,
  input  logic [4:0]      wa_i,
  input  logic [XLEN-1:0] wd_i,
  output logic [XLEN-1:0] rd1_o,
  output logic [XLEN-1:0] rd2_o
);

  localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

  logic [XLEN-1:0] mem_q [NREG];
  logic            wr_en_s;
  logic            ok1_s;
  logic            ok2_s;

  assign wr_en_s = we_i && (wa_i != 5'd0) && ({1'b0, wa_i} < 6'(NREG));
  assign ok1_s   = (ra1_i != 5'd0) && ({1'b0, ra1_i} < 6'(NREG));
  assign ok2_s   = (ra2_i != 5'd0) && ({1'b0, ra2_i} < 6'(NREG));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_s) begin
      mem_q[wa_i[AW-1:0]] <= wd_i;
    end
  end

  always_comb begin
    rd1_o = '0;
    if (!ok1_s) begin
      rd1_o = '0;
    end else if ((BYPASS != 0) && wr_en_s && (wa_i == ra1_i)) begin
      rd1_o = wd_i;
    end else begin
      rd1_o = mem_q[ra1_i[AW-1:0]];
    end
  end

  always_comb begin
    rd2_o = '0;
    if (!ok2_s) begin
      rd2_o = '0;
    end else if ((BYPASS != 0) && wr_en_s && (wa_i == ra2_i)) begin
      rd2_o = wd_i;
    end else begin
      rd2_o = mem_q[ra2_i[AW-1:0]];
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode stage plus ID/EX pipeline register: operand read, load-use stall,
// bubble insertion on stall/flush and a saturating bubble counter.
module id_ex_stage
  import decode_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instrD,
  input  logic            validD,
  input  logic [XLEN-1:0] ResultW,
  input  logic            RegWriteW,
  input  logic [4:0]      RdW,
  input  logic            flushE,
  output logic            stallD,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] ExtimmE,
  output logic            RegWriteE,
  output logic            JumpE,
  output logic            BranchE,
  output logic            mux2E,
  output logic            mux3E,
  output logic            mux4E,
  output logic [1:0]      ResultSrcE,
  output logic [2:0]      MemWriteE,
  output logic [2:0]      MemReadE,
  output logic [4:0]      AluControlE,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE,
  output logic            validE,
  output logic            illegalE,
  output logic [15:0]     bubble_cnt
);

  logic [4:0]      rs1_s, rs2_s, rd_s;
  logic [XLEN-1:0] rd1_s, rd2_s, op1_s, op2_s;
  logic            illegal_s, haz_s, bubble_s;
  ctrl_t           ctrl_s, ctrl_q;
  logic [XLEN-1:0] rd1_q, rd2_q, imm_q;
  logic [4:0]      rs1_q, rs2_q, rde_q;
  logic            valid_q, illegal_q;
  logic [15:0]     bcnt_q, bcnt_d;

  assign rs1_s = instrD[RS1_LSB +: 5];
  assign rs2_s = instrD[RS2_LSB +: 5];
  assign rd_s  = instrD[RD_LSB +: 5];

  assign illegal_s = ({1'b0, rs1_s} >= 6'(NREG)) || ({1'b0, rs2_s} >= 6'(NREG))
                  || ({1'b0, rd_s} >= 6'(NREG));

  rv_regfile #(.XLEN(XLEN), .NREG(NREG), .BYPASS(BYPASS)) u_rf (
    .clk   (clk),
    .rst   (rst),
    .ra1_i (rs1_s),
    .ra2_i (rs2_s),
    .we_i  (RegWriteW),
    .wa_i  (RdW),
    .wd_i  (ResultW),
    .rd1_o (rd1_s),
    .rd2_o (rd2_s)
  );

  assign op1_s = illegal_s ? '0 : rd1_s;
  assign op2_s = illegal_s ? '0 : rd2_s;

  // An illegal index still flows down the pipe but must not touch state.
  always_comb begin
    ctrl_s = decode_ctrl(instrD);
    if (!validD) begin
      ctrl_s = CTRL_NOP;
    end else if (illegal_s) begin
      ctrl_s.RegWrite = 1'b0;
      ctrl_s.MemWrite = MEM_NONE;
      ctrl_s.MemRead  = MEM_NONE;
    end else begin
      ctrl_s = decode_ctrl(instrD);
    end
  end

  assign haz_s    = valid_q && (ctrl_q.MemRead != MEM_NONE) && (rde_q != 5'd0)
                 && ((rde_q == rs1_s) || (rde_q == rs2_s));
  assign stallD   = haz_s && !flushE;
  assign bubble_s = flushE || haz_s;
  assign bcnt_d   = (bcnt_q == 16'hFFFF) ? bcnt_q : bcnt_q + 16'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q    <= CTRL_NOP;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      rd1_q     <= '0;
      rd2_q     <= '0;
      imm_q     <= '0;
      rs1_q     <= 5'd0;
      rs2_q     <= 5'd0;
      rde_q     <= 5'd0;
      bcnt_q    <= 16'd0;
    end else if (bubble_s) begin
      ctrl_q    <= CTRL_NOP;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      rd1_q     <= '0;
      rd2_q     <= '0;
      imm_q     <= '0;
      rs1_q     <= 5'd0;
      rs2_q     <= 5'd0;
      rde_q     <= 5'd0;
      bcnt_q    <= bcnt_d;
    end else begin
      ctrl_q    <= ctrl_s;
      valid_q   <= validD;
      illegal_q <= validD && illegal_s;
      rd1_q     <= op1_s;
      rd2_q     <= op2_s;
      imm_q     <= ext_imm(instrD);
      rs1_q     <= rs1_s;
      rs2_q     <= rs2_s;
      rde_q     <= rd_s;
    end
  end

  assign RD1E        = rd1_q;
  assign RD2E        = rd2_q;
  assign ExtimmE     = imm_q;
  assign RegWriteE   = ctrl_q.RegWrite;
  assign JumpE       = ctrl_q.Jump;
  assign BranchE     = ctrl_q.Branch;
  assign mux2E       = ctrl_q.mux2;
  assign mux3E       = ctrl_q.mux3;
  assign mux4E       = ctrl_q.mux4;
  assign ResultSrcE  = ctrl_q.ResultSrc;
  assign MemWriteE   = ctrl_q.MemWrite;
  assign MemReadE    = ctrl_q.MemRead;
  assign AluControlE = ctrl_q.AluControl;
  assign Rs1E        = rs1_q;
  assign Rs2E        = rs2_q;
  assign RdE         = rde_q;
  assign validE      = valid_q;
  assign illegalE    = illegal_q;
  assign bubble_cnt  = bcnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: three instances sharing stimulus
// (no bypass / bypass / RV32E register count).
module tb_id_ex_stage;

  localparam int NB  = 0;
  localparam int M   = 1;
  localparam int R16 = 2;

  localparam logic [31:0] I_SW      = 32'hFE20_AE23; // sw   x2,-4(x1)
  localparam logic [31:0] I_ADD655  = 32'h0002_8333; // add  x6,x5,x0
  localparam logic [31:0] I_ADD600  = 32'h0000_0333; // add  x6,x0,x0
  localparam logic [31:0] I_LW7     = 32'h0000_A383; // lw   x7,0(x1)
  localparam logic [31:0] I_ADD872  = 32'h0023_8433; // add  x8,x7,x2
  localparam logic [31:0] I_ADDI20  = 32'h0010_8A13; // addi x20,x1,1
  localparam logic [31:0] I_ADD610  = 32'h0000_8333; // add  x6,x1,x0
  localparam logic [31:0] I_ADD651  = 32'h0012_8333; // add  x6,x5,x1

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instrD;
  logic        validD;
  logic [31:0] ResultW;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic        flushE;

  logic        stall [3];
  logic [31:0] rd1e [3], rd2e [3], imme [3];
  logic        regwr [3], jump [3], branch [3], m2 [3], m3 [3], m4 [3];
  logic [1:0]  rsrc [3];
  logic [2:0]  mw [3], mr [3];
  logic [4:0]  alu [3], rs1e [3], rs2e [3], rde [3];
  logic        vale [3], ille [3];
  logic [15:0] bcnt [3];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    id_ex_stage #(
      .XLEN   (32),
      .NREG   ((g == 2) ? 16 : 32),
      .BYPASS ((g == 0) ? 0 : 1)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .instrD      (instrD),
      .validD      (validD),
      .ResultW     (ResultW),
      .RegWriteW   (RegWriteW),
      .RdW         (RdW),
      .flushE      (flushE),
      .stallD      (stall[g]),
      .RD1E        (rd1e[g]),
      .RD2E        (rd2e[g]),
      .ExtimmE     (imme[g]),
      .RegWriteE   (regwr[g]),
      .JumpE       (jump[g]),
      .BranchE     (branch[g]),
      .mux2E       (m2[g]),
      .mux3E       (m3[g]),
      .mux4E       (m4[g]),
      .ResultSrcE  (rsrc[g]),
      .MemWriteE   (mw[g]),
      .MemReadE    (mr[g]),
      .AluControlE (alu[g]),
      .Rs1E        (rs1e[g]),
      .Rs2E        (rs2e[g]),
      .RdE         (rde[g]),
      .validE      (vale[g]),
      .illegalE    (ille[g]),
      .bubble_cnt  (bcnt[g])
    );
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (vale[M] !== 1'b0) begin failures++; $display("FAIL reset_validE got=%b exp=0", vale[M]); end
    checks++; if (regwr[M] !== 1'b0) begin failures++; $display("FAIL reset_RegWriteE got=%b exp=0", regwr[M]); end
    checks++; if (bcnt[M] !== 16'd0) begin failures++; $display("FAIL reset_bubble_cnt got=%0d exp=0", bcnt[M]); end
    checks++; if (stall[M] !== 1'b0) begin failures++; $display("FAIL reset_stallD got=%b exp=0", stall[M]); end
    checks++; if (rd1e[M] !== 32'h0) begin failures++; $display("FAIL reset_RD1E got=%h exp=0", rd1e[M]); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_decode();
    instrD = I_SW; validD = 1'b1;
    step();
    checks++; if (imme[M] !== 32'hFFFF_FFFC) begin failures++; $display("FAIL sw_imm got=%h exp=fffffffc", imme[M]); end
    checks++; if ((mw[M] != 3'd0) !== 1'b1) begin failures++; $display("FAIL sw_memwrite got=%0d exp=nonzero", mw[M]); end
    checks++; if (regwr[M] !== 1'b0) begin failures++; $display("FAIL sw_regwrite got=%b exp=0", regwr[M]); end
    checks++; if (mr[M] !== 3'd0) begin failures++; $display("FAIL sw_memread got=%0d exp=0", mr[M]); end
    instrD = I_ADD655; validD = 1'b0;
    step();
    checks++; if (vale[M] !== 1'b0) begin failures++; $display("FAIL novalid_validE got=%b exp=0", vale[M]); end
    checks++; if (regwr[M] !== 1'b0) begin failures++; $display("FAIL novalid_regwrite got=%b exp=0", regwr[M]); end
    checks++; if (bcnt[M] !== 16'd0) begin failures++; $display("FAIL novalid_bubble_cnt got=%0d exp=0", bcnt[M]); end
  endtask

  task automatic test_bypass();
    RegWriteW = 1'b1; RdW = 5'd5; ResultW = 32'h0000_1234;
    instrD = I_ADD655; validD = 1'b1;
    step();
    checks++; if (rd1e[M] !== 32'h1234) begin failures++; $display("FAIL bypass_rd1 got=%h exp=00001234", rd1e[M]); end
    checks++; if (rd1e[NB] !== 32'h0) begin failures++; $display("FAIL nobypass_rd1_old got=%h exp=0", rd1e[NB]); end
    checks++; if (regwr[M] !== 1'b1) begin failures++; $display("FAIL add_regwrite got=%b exp=1", regwr[M]); end
    checks++; if (rde[M] !== 5'd6) begin failures++; $display("FAIL add_rd got=%0d exp=6", rde[M]); end
    RegWriteW = 1'b0;
    step();
    checks++; if (rd1e[NB] !== 32'h1234) begin failures++; $display("FAIL nobypass_rd1_next got=%h exp=00001234", rd1e[NB]); end
  endtask

  task automatic test_x0();
    RegWriteW = 1'b1; RdW = 5'd0; ResultW = 32'hFFFF_FFFF;
    instrD = I_ADD600; validD = 1'b1;
    step();
    checks++; if (rd1e[M] !== 32'h0) begin failures++; $display("FAIL x0_bypass_rd1 got=%h exp=0", rd1e[M]); end
    RegWriteW = 1'b0;
    step();
    checks++; if (rd1e[M] !== 32'h0) begin failures++; $display("FAIL x0_read_rd1 got=%h exp=0", rd1e[M]); end
    checks++; if (rd2e[M] !== 32'h0) begin failures++; $display("FAIL x0_read_rd2 got=%h exp=0", rd2e[M]); end
  endtask

  task automatic test_load_use();
    instrD = I_LW7; validD = 1'b1;
    step();
    checks++; if ((mr[M] != 3'd0) !== 1'b1) begin failures++; $display("FAIL lw_memread got=%0d exp=nonzero", mr[M]); end
    checks++; if (rde[M] !== 5'd7) begin failures++; $display("FAIL lw_rd got=%0d exp=7", rde[M]); end
    instrD = I_ADD872;
    #1;
    checks++; if (stall[M] !== 1'b1) begin failures++; $display("FAIL lu_stall got=%b exp=1", stall[M]); end
    step();
    checks++; if (vale[M] !== 1'b0) begin failures++; $display("FAIL lu_bubble_valid got=%b exp=0", vale[M]); end
    checks++; if (regwr[M] !== 1'b0) begin failures++; $display("FAIL lu_bubble_regwrite got=%b exp=0", regwr[M]); end
    checks++; if (bcnt[M] !== 16'd1) begin failures++; $display("FAIL lu_bubble_cnt got=%0d exp=1", bcnt[M]); end
    checks++; if (stall[M] !== 1'b0) begin failures++; $display("FAIL lu_stall_drop got=%b exp=0", stall[M]); end
    step();
    checks++; if (vale[M] !== 1'b1) begin failures++; $display("FAIL lu_add_valid got=%b exp=1", vale[M]); end
    checks++; if (rs1e[M] !== 5'd7) begin failures++; $display("FAIL lu_add_rs1 got=%0d exp=7", rs1e[M]); end
    checks++; if (rde[M] !== 5'd8) begin failures++; $display("FAIL lu_add_rd got=%0d exp=8", rde[M]); end
    checks++; if (bcnt[M] !== 16'd1) begin failures++; $display("FAIL lu_cnt_hold got=%0d exp=1", bcnt[M]); end
  endtask

  task automatic test_flush_haz();
    instrD = I_LW7; validD = 1'b1;
    step();
    instrD = I_ADD872; flushE = 1'b1;
    #1;
    checks++; if (stall[M] !== 1'b0) begin failures++; $display("FAIL fh_stall got=%b exp=0", stall[M]); end
    step();
    flushE = 1'b0;
    checks++; if (vale[M] !== 1'b0) begin failures++; $display("FAIL fh_bubble_valid got=%b exp=0", vale[M]); end
    checks++; if (bcnt[M] !== 16'd2) begin failures++; $display("FAIL fh_bubble_cnt got=%0d exp=2", bcnt[M]); end
    step();
    checks++; if (rde[M] !== 5'd8) begin failures++; $display("FAIL fh_add_rd got=%0d exp=8", rde[M]); end
    checks++; if (bcnt[M] !== 16'd2) begin failures++; $display("FAIL fh_cnt_hold got=%0d exp=2", bcnt[M]); end
  endtask

  task automatic test_illegal();
    RegWriteW = 1'b1; RdW = 5'd1; ResultW = 32'h0000_0055;
    instrD = 32'h0; validD = 1'b0;
    step();
    RegWriteW = 1'b0;
    instrD = I_ADDI20; validD = 1'b1;
    step();
    checks++; if (ille[R16] !== 1'b1) begin failures++; $display("FAIL ill_illegalE got=%b exp=1", ille[R16]); end
    checks++; if (regwr[R16] !== 1'b0) begin failures++; $display("FAIL ill_regwrite got=%b exp=0", regwr[R16]); end
    checks++; if (rd1e[R16] !== 32'h0) begin failures++; $display("FAIL ill_rd1 got=%h exp=0", rd1e[R16]); end
    checks++; if (vale[R16] !== 1'b1) begin failures++; $display("FAIL ill_valid got=%b exp=1", vale[R16]); end
    checks++; if (ille[M] !== 1'b0) begin failures++; $display("FAIL legal32_illegalE got=%b exp=0", ille[M]); end
    checks++; if (regwr[M] !== 1'b1) begin failures++; $display("FAIL legal32_regwrite got=%b exp=1", regwr[M]); end
    checks++; if (imme[M] !== 32'h1) begin failures++; $display("FAIL addi_imm got=%h exp=1", imme[M]); end
    checks++; if (rd1e[M] !== 32'h55) begin failures++; $display("FAIL addi_rd1 got=%h exp=55", rd1e[M]); end
    instrD = I_ADD610;
    step();
    checks++; if (rd1e[R16] !== 32'h55) begin failures++; $display("FAIL ill_x1_kept got=%h exp=55", rd1e[R16]); end
    checks++; if (ille[R16] !== 1'b0) begin failures++; $display("FAIL ill_clear got=%b exp=0", ille[R16]); end
  endtask

  task automatic test_async_reset();
    instrD = I_LW7; validD = 1'b1;
    step();
    instrD = I_ADD872;
    #1;
    checks++; if (stall[M] !== 1'b1) begin failures++; $display("FAIL ar_stall_pre got=%b exp=1", stall[M]); end
    #1;
    rst = 1'b1;
    #1;
    checks++; if (vale[M] !== 1'b0) begin failures++; $display("FAIL ar_validE got=%b exp=0", vale[M]); end
    checks++; if (rde[M] !== 5'd0) begin failures++; $display("FAIL ar_RdE got=%0d exp=0", rde[M]); end
    checks++; if (mr[M] !== 3'd0) begin failures++; $display("FAIL ar_MemReadE got=%0d exp=0", mr[M]); end
    checks++; if (bcnt[M] !== 16'd0) begin failures++; $display("FAIL ar_bubble_cnt got=%0d exp=0", bcnt[M]); end
    checks++; if (stall[M] !== 1'b0) begin failures++; $display("FAIL ar_stallD got=%b exp=0", stall[M]); end
    checks++; if (rs1e[M] !== 5'd0) begin failures++; $display("FAIL ar_Rs1E got=%0d exp=0", rs1e[M]); end
    @(negedge clk);
    rst = 1'b0;
    instrD = I_ADD651;
    step();
    checks++; if (rd1e[M] !== 32'h0) begin failures++; $display("FAIL ar_x5_cleared got=%h exp=0", rd1e[M]); end
    checks++; if (rd2e[M] !== 32'h0) begin failures++; $display("FAIL ar_x1_cleared got=%h exp=0", rd2e[M]); end
    checks++; if (vale[M] !== 1'b1) begin failures++; $display("FAIL ar_resume_valid got=%b exp=1", vale[M]); end
  endtask

  initial begin
    rst = 1'b1;
    instrD = 32'h0;
    validD = 1'b0;
    ResultW = 32'h0;
    RegWriteW = 1'b0;
    RdW = 5'd0;
    flushE = 1'b0;
    test_reset();
    test_decode();
    test_bypass();
    test_x0();
    test_load_use();
    test_flush_haz();
    test_illegal();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
